// File: rtl/swi_debounce_pkg.sv
// swi_debounce_pkg
// Shared types and defaults for the switch-bank debouncer.
//   deb_state_t             : per-bit debounce FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES : number of consecutive samples a new level
//                             must persist before it is accepted
package swi_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
// Debounces a single switch bit with a 4-state FSM and a stability counter.
// Ports:
//   clk_2   in  system clock, posedge active
//   reset   in  asynchronous active-low reset
//   sample  in  switch level (raw or synchronized) sampled every posedge
//   stable  out debounced level
//   rise    out one-cycle pulse when stable goes 0->1
//   fall    out one-cycle pulse when stable goes 1->0
//   toggle  out flip-flop inverted on every rise
module debounce_bit
  import swi_debounce_pkg::*;
#(
  parameter int  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_2,
  input  logic reset,
  input  logic sample,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic toggle
);

  // The counter holds how many consecutive samples of the new level have
  // been seen; acceptance happens on the sample that makes it DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  deb_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state  <= S_LOW;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      // Pulses are only ever asserted for the single cycle of acceptance.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LOW: begin
          if (sample) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state  <= S_HIGH;
              stable <= 1'b1;
              rise   <= 1'b1;
              toggle <= ~toggle;
              cnt    <= '0;
            end else begin
              state <= S_WAIT_HI;
              cnt   <= CNT_ONE;
            end
          end
        end
        S_WAIT_HI: begin
          if (!sample) begin
            // Bounce: drop back without any pulse.
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= S_HIGH;
            stable <= 1'b1;
            rise   <= 1'b1;
            toggle <= ~toggle;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sample) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state  <= S_LOW;
              stable <= 1'b0;
              fall   <= 1'b1;
              cnt    <= '0;
            end else begin
              state <= S_WAIT_LO;
              cnt   <= CNT_ONE;
            end
          end
        end
        S_WAIT_LO: begin
          if (sample) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= S_LOW;
            stable <= 1'b0;
            fall   <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/swi_debounce.sv
// swi_debounce
// Conditions the raw switch bank into debounced levels, edge pulses and
// rise-toggled latches, one independent debouncer per bit.
// Optional build macro SWI_SYNC_EN: adds a 2-flop synchronizer per bit in
// front of the debouncers (latency DEBOUNCE_CYCLES+2 instead of
// DEBOUNCE_CYCLES edges).
// Ports:
//   clk_2       in  system clock, posedge active
//   reset       in  asynchronous active-low reset
//   SWI         in  raw switch levels (asynchronous to clk_2)
//   swi_stable  out debounced level per bit
//   swi_rise    out one-cycle pulse per bit on 0->1 of swi_stable
//   swi_fall    out one-cycle pulse per bit on 1->0 of swi_stable
//   swi_toggle  out per-bit latch inverted on every swi_rise
module swi_debounce
  import swi_debounce_pkg::*;
#(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] swi_stable,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic [NBITS-1:0] swi_toggle
);

  logic [NBITS-1:0] sample;

`ifdef SWI_SYNC_EN
  logic [NBITS-1:0] sync_meta;
  logic [NBITS-1:0] sync_q;

  // Two-stage synchronizer; only sync_q is ever looked at by the FSMs.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= SWI;
      sync_q    <= sync_meta;
    end
  end

  assign sample = sync_q;
`else
  assign sample = SWI;
`endif

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_2  (clk_2),
      .reset  (reset),
      .sample (sample[i]),
      .stable (swi_stable[i]),
      .rise   (swi_rise[i]),
      .fall   (swi_fall[i]),
      .toggle (swi_toggle[i])
    );
  end

endmodule

// File: tb/tb_swi_debounce.sv
// tb_swi_debounce
// Self-checking bench for swi_debounce at default parameters (8 bits,
// 4-cycle debounce). Works with or without SWI_SYNC_EN defined.
module tb_swi_debounce;

  localparam int D = 4;
`ifdef SWI_SYNC_EN
  localparam int OFF = 2;
`else
  localparam int OFF = 0;
`endif
  localparam int LAT = D + OFF;

  logic       clk_2;
  logic       reset;
  logic [7:0] SWI;
  logic [7:0] swi_stable, swi_rise, swi_fall, swi_toggle;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;

  typedef struct {
    logic [7:0] swi;
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic [7:0] tg;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          due;
    int          row;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  swi_debounce dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .SWI        (SWI),
    .swi_stable (swi_stable),
    .swi_rise   (swi_rise),
    .swi_fall   (swi_fall),
    .swi_toggle (swi_toggle)
  );

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] outs();
    return {swi_stable, swi_rise, swi_fall, swi_toggle};
  endfunction

  task automatic tick();
    @(posedge clk_2);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic [7:0] s);
    SWI = s;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got st=%h ri=%h fa=%h tg=%h, expected st=%h ri=%h fa=%h tg=%h",
               name, act[31:24], act[23:16], act[15:8], act[7:0],
               exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic addRow(input logic [7:0] s, input logic [7:0] st, input logic [7:0] ri,
                        input logic [7:0] fa, input logic [7:0] tg);
    vec_t v;
    v.swi = s; v.st = st; v.ri = ri; v.fa = fa; v.tg = tg;
    vecs.push_back(v);
  endtask

  task automatic serviceScoreboard();
    while (sb_q.size() > 0 && sb_q[0].due == cycle) begin
      sb_t e;
      e = sb_q.pop_front();
      checkOutput($sformatf("row%0d", e.row), outs(), e.exp);
    end
  endtask

  initial begin
    // Table: inputs applied before each posedge, outputs expected right after
    // that posedge in the unsynchronized build (shifted by OFF otherwise).
    // Clean press of bit 3
    addRow(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    addRow(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    addRow(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    addRow(8'h08, 8'h08, 8'h08, 8'h00, 8'h08);
    addRow(8'h08, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h08, 8'h08, 8'h00, 8'h00, 8'h08);
    // Bounce on bit 0: 1,0,1,1,0 then 0
    addRow(8'h09, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h08, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h09, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h09, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h08, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h08, 8'h08, 8'h00, 8'h00, 8'h08);
    // Release bit 3
    addRow(8'h00, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h00, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h00, 8'h08, 8'h00, 8'h00, 8'h08);
    addRow(8'h00, 8'h00, 8'h00, 8'h08, 8'h08);
    addRow(8'h00, 8'h00, 8'h00, 8'h00, 8'h08);
    // Four bits at once
    addRow(8'hF0, 8'h00, 8'h00, 8'h00, 8'h08);
    addRow(8'hF0, 8'h00, 8'h00, 8'h00, 8'h08);
    addRow(8'hF0, 8'h00, 8'h00, 8'h00, 8'h08);
    addRow(8'hF0, 8'hF0, 8'hF0, 8'h00, 8'hF8);
    addRow(8'hF0, 8'hF0, 8'h00, 8'h00, 8'hF8);
    // Bit 7 low for one cycle short of acceptance
    addRow(8'h70, 8'hF0, 8'h00, 8'h00, 8'hF8);
    addRow(8'h70, 8'hF0, 8'h00, 8'h00, 8'hF8);
    addRow(8'h70, 8'hF0, 8'h00, 8'h00, 8'hF8);
    addRow(8'hF0, 8'hF0, 8'h00, 8'h00, 8'hF8);
    addRow(8'hF0, 8'hF0, 8'h00, 8'h00, 8'hF8);
    // Bit 1 press/release twice, 6 cycles per level
    for (int p = 0; p < 2; p++) begin
      logic [7:0] tg_after;
      tg_after = (p == 0) ? 8'hFA : 8'hF8;
      addRow(8'hF2, 8'hF0, 8'h00, 8'h00, (p == 0) ? 8'hF8 : 8'hFA);
      addRow(8'hF2, 8'hF0, 8'h00, 8'h00, (p == 0) ? 8'hF8 : 8'hFA);
      addRow(8'hF2, 8'hF0, 8'h00, 8'h00, (p == 0) ? 8'hF8 : 8'hFA);
      addRow(8'hF2, 8'hF2, 8'h02, 8'h00, tg_after);
      addRow(8'hF2, 8'hF2, 8'h00, 8'h00, tg_after);
      addRow(8'hF2, 8'hF2, 8'h00, 8'h00, tg_after);
      addRow(8'hF0, 8'hF2, 8'h00, 8'h00, tg_after);
      addRow(8'hF0, 8'hF2, 8'h00, 8'h00, tg_after);
      addRow(8'hF0, 8'hF2, 8'h00, 8'h00, tg_after);
      addRow(8'hF0, 8'hF0, 8'h00, 8'h02, tg_after);
      addRow(8'hF0, 8'hF0, 8'h00, 8'h00, tg_after);
      addRow(8'hF0, 8'hF0, 8'h00, 8'h00, tg_after);
    end

    // Reset held with all switches up
    reset = 1'b0;
    SWI   = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 4 || k == 9) checkOutput($sformatf("reset_hold_%0d", k), outs(), 32'h0);
    end

    // Clean acceptance of all bits after release
    SWI   = 8'h00;
    reset = 1'b1;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    for (int k = 1; k <= LAT + 1; k++) begin
      applyStimulus(8'hFF);
      if (k == LAT - 1) checkOutput("pre_accept", outs(), 32'h0);
      if (k == LAT)     checkOutput("accept", outs(), 32'hFFFF00FF);
      if (k == LAT + 1) checkOutput("accept_next", outs(), 32'hFF0000FF);
    end
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("mid_wait", outs(), 32'hFF0000FF);

    // Reset asserted mid-cycle must clear outputs without a clock edge
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_clear", outs(), 32'h0);
    SWI = 8'hFF;
    tick();
    checkOutput("async_hold", outs(), 32'h0);

    // Release mid-cycle with switches up: a full fresh debounce follows
    #3;
    reset = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == LAT - 1) checkOutput("fresh_pre", outs(), 32'h0);
      if (k == LAT)     checkOutput("fresh_accept", outs(), 32'hFFFF00FF);
      if (k == LAT + 1) checkOutput("fresh_next", outs(), 32'hFF0000FF);
    end
    for (int k = 1; k <= LAT; k++) begin
      applyStimulus(8'h00);
      if (k == LAT - 1) checkOutput("release_pre", outs(), 32'hFF0000FF);
      if (k == LAT)     checkOutput("release", outs(), 32'h0000FFFF);
    end

    // Clean restart for the table
    reset = 1'b0;
    SWI   = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("table_start", outs(), 32'h0);

    foreach (vecs[i]) begin
      sb_t e;
      e.exp = {vecs[i].st, vecs[i].ri, vecs[i].fa, vecs[i].tg};
      e.due = cycle + 1 + OFF;
      e.row = i;
      sb_q.push_back(e);
      applyStimulus(vecs[i].swi);
      serviceScoreboard();
    end
    for (int k = 0; k < OFF + 3 && sb_q.size() > 0; k++) begin
      tick();
      serviceScoreboard();
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
